// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment table for the 7-segment display path.
// Segment bytes are active-low: [0]=a .. [6]=g, [7]=dp (always off).
package seg_pkg;

    localparam logic [7:0] SEG_BLANK      = 8'hFF;
    localparam logic [7:0] FRAME_START_EN = 8'hFE;

    function automatic logic [7:0] hexseg(input logic [3:0] nib);
        logic [7:0] seg;
        unique case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low segment lookup.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = hexseg(nibble);

endmodule

// File: rtl/seg_display_ctrl.sv
// 8-digit hex display driver with tear-free updates applied at the scan frame boundary.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned         DIGITS      = 8,
    parameter logic [4*DIGITS-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [4*DIGITS-1:0]   wdata,
    input  logic [DIGITS-1:0]     led_en,
    output logic [DIGITS-1:0]     an_out,
    output logic [7:0]            seg_out,
    output logic                  pending
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] FRAME_START = ~(DIGITS'(1));

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic [DIGITS-1:0]   prev_en_q;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                pending_q, pending_d;

    logic                fb;
    logic                digit_valid;
    logic [IDX_W-1:0]    digit_idx;
    logic [3:0]          nibble;
    logic [7:0]          hex_seg;
    logic                lz_blank;

    // Data and frame-boundary control
    always_comb begin
        fb        = (led_en == FRAME_START) && (prev_en_q != FRAME_START);
        active_d  = fb ? shadow_q : active_q;
        shadow_d  = wen ? wdata : shadow_q;
        pending_d = wen | (pending_q & ~fb);
    end

    // Digit 0 of a new frame must already show the newly applied value, so the
    // mux reads active_d rather than active_q.
    always_comb begin
        digit_valid = $onehot(~led_en);
        digit_idx   = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!led_en[i]) digit_idx = IDX_W'(i);
        end
        nibble = active_d[{digit_idx, 2'b00} +: 4];
    end

    seg_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg    (hex_seg)
    );

`ifdef SEG_LZB_EN
    logic [IDX_W-1:0] msd_idx;

    always_comb begin
        msd_idx = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (active_d[4*i +: 4] != 4'h0) msd_idx = IDX_W'(i);
        end
        lz_blank = digit_idx > msd_idx;
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Invalid enable patterns blank everything to avoid ghosting.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (digit_valid) begin
            an_d  = led_en;
            seg_d = lz_blank ? SEG_BLANK : hex_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= RESET_VALUE;
            active_q  <= RESET_VALUE;
            prev_en_q <= '1;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            prev_en_q <= led_en;
            an_q      <= an_d;
            seg_q     <= seg_d;
            pending_q <= pending_d;
        end
    end

    assign an_out  = an_q;
    assign seg_out = seg_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl; expectations follow SEG_LZB_EN when defined.
module tb_seg_display_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  led_en;
    logic [7:0]  an_out;
    logic [7:0]  seg_out;
    logic        pending;

    int n_cmp;
    int n_err;

    seg_display_ctrl #(
        .DIGITS      (8),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wen     (wen),
        .wdata   (wdata),
        .led_en  (led_en),
        .an_out  (an_out),
        .seg_out (seg_out),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_tbl(input logic [3:0] n);
        logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    function automatic logic [7:0] exp_seg(input logic [31:0] val, input int i);
`ifdef SEG_LZB_EN
        int msd = 0;
        for (int k = 0; k < 8; k++) if (val[4*k +: 4] != 4'h0) msd = k;
        if (i > msd) return 8'hFF;
`endif
        return hex_tbl(val[4*i +: 4]);
    endfunction

    task automatic step(input logic [7:0] en, input logic w, input logic [31:0] wd);
        led_en = en;
        wen    = w;
        wdata  = wd;
        @(posedge clk);
        #1;
        wen = 1'b0;
    endtask

    // Scan digits first..7 and check each registered digit against val.
    task automatic scan(input logic [31:0] val, input int first, input string tag);
        logic [7:0] en;
        for (int i = first; i < 8; i++) begin
            en = ~(8'h01 << i);
            step(en, 1'b0, 32'h0);
            check($sformatf("%s_an%0d", tag, i), {24'h0, an_out}, {24'h0, en});
            check($sformatf("%s_seg%0d", tag, i), {24'h0, seg_out}, {24'h0, exp_seg(val, i)});
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        wen    = 1'b0;
        wdata  = 32'h0;
        led_en = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", {24'h0, an_out}, 32'hFF);
        check("rst_seg", {24'h0, seg_out}, 32'hFF);
        check("rst_pend", {31'h0, pending}, 32'h0);
        rst_n = 1'b1;
        step(8'hFF, 1'b0, 32'h0);

        // 1: reset value scan
        scan(32'h0, 0, "t1");

        // 2: mid-frame write, old value held until next boundary
        scan(32'h0, 0, "t2a");
        step(8'hFE, 1'b0, 32'h0);
        step(8'hFD, 1'b0, 32'h0);
        step(8'hFB, 1'b1, 32'h89AB_CDEF);
        check("t2_old_seg2", {24'h0, seg_out}, {24'h0, exp_seg(32'h0, 2)});
        check("t2_pend", {31'h0, pending}, 32'h1);
        scan(32'h0, 3, "t2b");
        check("t2_pend_hold", {31'h0, pending}, 32'h1);
        scan(32'h89AB_CDEF, 0, "t2c");
        check("t2_dig0", {24'h0, exp_seg(32'h89AB_CDEF, 0)}, 32'h8E);
        check("t2_pend_clr", {31'h0, pending}, 32'h0);

        // 3: write on the boundary cycle itself
        step(8'hFE, 1'b1, 32'h0000_0001);
        check("t3_seg0", {24'h0, seg_out}, 32'h8E);
        check("t3_pend", {31'h0, pending}, 32'h1);
        scan(32'h89AB_CDEF, 1, "t3a");
        check("t3_pend_hold", {31'h0, pending}, 32'h1);
        step(8'hFE, 1'b0, 32'h0);
        check("t3_new0", {24'h0, seg_out}, 32'hF9);
        check("t3_pend_clr", {31'h0, pending}, 32'h0);
        scan(32'h0000_0001, 1, "t3b");

        // 4: invalid enables blank
        step(8'hFC, 1'b0, 32'h0);
        check("t4_an_fc", {24'h0, an_out}, 32'hFF);
        check("t4_seg_fc", {24'h0, seg_out}, 32'hFF);
        step(8'hFF, 1'b0, 32'h0);
        check("t4_an_ff", {24'h0, an_out}, 32'hFF);
        check("t4_seg_ff", {24'h0, seg_out}, 32'hFF);

        // 5: reset mid-frame with pending write
        step(8'hFE, 1'b0, 32'h0);
        step(8'hFD, 1'b1, 32'h1234_5678);
        check("t5_pend", {31'h0, pending}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_an", {24'h0, an_out}, 32'hFF);
        check("t5_seg", {24'h0, seg_out}, 32'hFF);
        check("t5_pend_clr", {31'h0, pending}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'hFF, 1'b0, 32'h0);
        scan(32'h0, 0, "t5");

        // 6: sparse value, blanking of upper zeros when enabled
        step(8'hFF, 1'b1, 32'h0000_0A00);
        scan(32'h0000_0A00, 0, "t6");
        check("t6_dig2", {24'h0, exp_seg(32'h0000_0A00, 2)}, 32'h88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
